fetch_stage: RTL

//  Instruction-fetch front end that feeds the decode/controller stage of the 3-stage pipeline.

---
 rtl/fetch_stage.sv | 106 ++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch front end: PC owner, single-outstanding imem request, decode handshake
module fetch_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            PCen,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_inst,
    input  logic            id_ready,
    output logic [XLEN-1:0] pc_out
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));
    localparam logic [XLEN-1:0] NOP_INST   = XLEN'(32'h0000_0013);

    state_t          state;
    logic [XLEN-1:0] pc;
    // set when the in-flight response belongs to a redirected-away path
    logic            drop;

    // The request pulse is the REQ state itself; held low while reset is asserted
    assign imem_req  = (state == S_REQ) && rst_n;
    assign imem_addr = pc;
    assign pc_out    = pc;

    // Fetch FSM: redirect has priority over every other event in every state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_REQ;
            pc       <= RESET_PC & ALIGN_MASK;
            drop     <= 1'b0;
            id_valid <= 1'b0;
            id_pc    <= '0;
            id_inst  <= NOP_INST;
        end else if (br_taken) begin
            pc       <= br_target & ALIGN_MASK;
            id_valid <= 1'b0;
            case (state)
                // request already on the bus with the old pc; its answer must be thrown away
                S_REQ: begin
                    drop  <= 1'b1;
                    state <= S_WAIT;
                end
                // a response landing together with the redirect is wrong-path by definition
                S_WAIT: begin
                    if (imem_rvalid) begin
                        drop  <= 1'b0;
                        state <= S_REQ;
                    end else begin
                        drop  <= 1'b1;
                    end
                end
                default: begin
                    drop  <= 1'b0;
                    state <= S_REQ;
                end
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= S_REQ;
                        end else begin
                            id_pc    <= pc;
                            id_inst  <= imem_rdata;
                            id_valid <= 1'b1;
                            state    <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    // a controller stall overrides decode readiness
                    if (id_ready && PCen) begin
                        id_valid <= 1'b0;
                        pc       <= pc + XLEN'(4);
                        state    <= S_REQ;
                    end
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

endmodule
